// File: rtl/tcm_dec_types.sv
`default_nettype none
// ============================================================================
// tcm_dec_types : shared TCM decoder types and constants
// Rev 1.0
// ============================================================================
package tcm_dec_types;

  // Pipeline depth of the downstream ACS tree, in cycles.
  localparam int cTREE_LAT = 4;

  typedef logic [9:0] trel_bm_t;
  typedef logic [3:0] symb_m_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/tcm_dec_tmu_sched_dly.sv
`default_nettype none
// ============================================================================
// tcm_dec_tmu_sched_dly : clock-enabled valid delay line covering RAM latency
// Rev 1.0
// ============================================================================
module tcm_dec_tmu_sched_dly #(
  parameter int pLAT = 1
) (
  input  logic iclk,
  input  logic ireset,
  input  logic iclkena,
  input  logic ival,
  output logic oval
);

  logic [pLAT-1:0] sr_q;

  generate
    if (pLAT == 1) begin : g_single
      always_ff @(posedge iclk) begin
        if (ireset)       sr_q <= '0;
        else if (iclkena) sr_q <= ival;
      end
    end else begin : g_chain
      always_ff @(posedge iclk) begin
        if (ireset)       sr_q <= '0;
        else if (iclkena) sr_q <= {sr_q[pLAT-2:0], ival};
      end
    end
  endgenerate

  assign oval = sr_q[pLAT-1];

endmodule
`default_nettype wire

// File: rtl/tcm_dec_tmu_sched.sv
`default_nettype none
// ============================================================================
// tcm_dec_tmu_sched : issues branch-metric RAM reads per 4D symbol and tags
//                     the ACS tree results with branch address, sop and eop
// Rev 1.0
// ============================================================================
module tcm_dec_tmu_sched
  import tcm_dec_types::*;
#(
  parameter int pBM_NUM  = 16,
  parameter int pRAM_LAT = 1
) (
  input  logic                       iclk,
  input  logic                       ireset,
  input  logic                       iclkena,
  input  logic                       ival,
  output logic                       ordy,
  output logic [$clog2(pBM_NUM)-1:0] oraddr,
  output logic                       oren,
  output logic                       otree_val,
  input  logic                       itree_val,
  input  trel_bm_t                   itree_bm,
  input  symb_m_idx_t                itree_idx,
  output logic                       oval,
  output logic                       osop,
  output logic                       oeop,
  output trel_bm_t                   obm,
  output logic [$clog2(pBM_NUM)-1:0] obm_addr,
  output symb_m_idx_t                osymb_m_idx,
  output logic                       obusy,
  output logic                       oerr
);

  localparam int             cAW   = $clog2(pBM_NUM);
  localparam int             cOW   = $clog2(pBM_NUM + 8) + 1;
  localparam logic [cAW-1:0] cLAST = cAW'(pBM_NUM - 1);

  sched_state_t   state_q;
  logic           oren_q;
  logic [cAW-1:0] raddr_q;
  logic [cAW-1:0] ret_q, ret_d;
  logic [cOW-1:0] outst_q, outst_d;
  logic           oval_q, osop_q, oeop_q, oerr_q;
  trel_bm_t       obm_q;
  logic [cAW-1:0] obm_addr_q;
  symb_m_idx_t    oidx_q;
  logic           tree_err, tree_ok;

  // A new symbol may start from IDLE, or seamlessly on the last branch read.
  assign ordy = (state_q == ST_IDLE) || ((state_q == ST_RUN) && (raddr_q == cLAST));

  assign tree_err = itree_val && (outst_q == '0);
  assign tree_ok  = itree_val && !tree_err;

  always_comb begin
    outst_d = outst_q;
    case ({otree_val, tree_ok})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase
    ret_d = (ret_q == cLAST) ? '0 : ret_q + 1'b1;
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      state_q <= ST_IDLE;
      oren_q  <= 1'b0;
      raddr_q <= '0;
    end else if (iclkena) begin
      case (state_q)
        ST_IDLE: begin
          if (ival) begin
            state_q <= ST_RUN;
            oren_q  <= 1'b1;
            raddr_q <= '0;
          end
        end
        ST_RUN: begin
          if (raddr_q == cLAST) begin
            raddr_q <= '0;
            if (!ival) begin
              state_q <= ST_DRAIN;
              oren_q  <= 1'b0;
            end
          end else begin
            raddr_q <= raddr_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          // Leave once the final result is on the output and nothing is in flight.
          if (oval_q && oeop_q && (outst_q == '0)) state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          oren_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      outst_q    <= '0;
      ret_q      <= '0;
      oval_q     <= 1'b0;
      osop_q     <= 1'b0;
      oeop_q     <= 1'b0;
      oerr_q     <= 1'b0;
      obm_q      <= '0;
      obm_addr_q <= '0;
      oidx_q     <= '0;
    end else if (iclkena) begin
      outst_q <= outst_d;
      oval_q  <= tree_ok;
      osop_q  <= tree_ok && (ret_q == '0);
      oeop_q  <= tree_ok && (ret_q == cLAST);
      if (tree_err) oerr_q <= 1'b1;
      if (tree_ok) begin
        ret_q      <= ret_d;
        obm_q      <= itree_bm;
        obm_addr_q <= ret_q;
        oidx_q     <= itree_idx;
      end
    end
  end

  tcm_dec_tmu_sched_dly #(
    .pLAT (pRAM_LAT)
  ) u_dly (
    .iclk    (iclk),
    .ireset  (ireset),
    .iclkena (iclkena),
    .ival    (oren_q),
    .oval    (otree_val)
  );

  assign oren        = oren_q;
  assign oraddr      = raddr_q;
  assign oval        = oval_q;
  assign osop        = osop_q;
  assign oeop        = oeop_q;
  assign obm         = obm_q;
  assign obm_addr    = obm_addr_q;
  assign osymb_m_idx = oidx_q;
  assign obusy       = (state_q != ST_IDLE);
  assign oerr        = oerr_q;

endmodule
`default_nettype wire

// File: tb/tb_tcm_dec_tmu_sched.sv
`default_nettype none
// ============================================================================
// tb_tcm_dec_tmu_sched : randomized bench for tcm_dec_tmu_sched with a RAM and
//                        ACS tree environment and a queue-based reference model
// Rev 1.0
// ============================================================================
module tb_tcm_dec_tmu_sched;
  import tcm_dec_types::*;

  localparam int NA  = 16;
  localparam int LA  = 1;
  localparam int NB  = 8;
  localparam int LB  = 3;
  localparam int AWA = $clog2(NA);
  localparam int AWB = $clog2(NB);
  localparam int TL  = cTREE_LAT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clkena, ival_a, spur_a, ival_b, one_b;

  logic           ordy_a, oren_a, otree_val_a, itree_val_a, oval_a, osop_a, oeop_a, obusy_a, oerr_a;
  logic [AWA-1:0] oraddr_a, obm_addr_a;
  trel_bm_t       itree_bm_a, obm_a;
  symb_m_idx_t    itree_idx_a, osymb_a;

  logic           ordy_b, oren_b, otree_val_b, itree_val_b, oval_b, osop_b, oeop_b, obusy_b, oerr_b;
  logic [AWB-1:0] oraddr_b, obm_addr_b;
  trel_bm_t       itree_bm_b, obm_b;
  symb_m_idx_t    itree_idx_b, osymb_b;

  tcm_dec_tmu_sched #(.pBM_NUM(NA), .pRAM_LAT(LA)) dut_a (
    .iclk(clk), .ireset(rst), .iclkena(clkena), .ival(ival_a), .ordy(ordy_a),
    .oraddr(oraddr_a), .oren(oren_a), .otree_val(otree_val_a),
    .itree_val(itree_val_a), .itree_bm(itree_bm_a), .itree_idx(itree_idx_a),
    .oval(oval_a), .osop(osop_a), .oeop(oeop_a), .obm(obm_a), .obm_addr(obm_addr_a),
    .osymb_m_idx(osymb_a), .obusy(obusy_a), .oerr(oerr_a)
  );

  tcm_dec_tmu_sched #(.pBM_NUM(NB), .pRAM_LAT(LB)) dut_b (
    .iclk(clk), .ireset(rst), .iclkena(one_b), .ival(ival_b), .ordy(ordy_b),
    .oraddr(oraddr_b), .oren(oren_b), .otree_val(otree_val_b),
    .itree_val(itree_val_b), .itree_bm(itree_bm_b), .itree_idx(itree_idx_b),
    .oval(oval_b), .osop(osop_b), .oeop(oeop_b), .obm(obm_b), .obm_addr(obm_addr_b),
    .osymb_m_idx(osymb_b), .obusy(obusy_b), .oerr(oerr_b)
  );

  // Metric table contents: branch k of symbol s has maximum 10*k.
  function automatic trel_bm_t bm_of(input int k);
    return trel_bm_t'(10 * k);
  endfunction

  function automatic symb_m_idx_t idx_of(input int s, input int k);
    return symb_m_idx_t'(s * 5 + k * 3);
  endfunction

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // RAM (read latency L) plus 4-stage tree, both frozen by the clock enable.
  logic [AWA-1:0] ram_a [LA];
  int             ram_sa[LA];
  int             sym_a;
  logic           tv_a  [TL];
  trel_bm_t       tbm_a [TL];
  symb_m_idx_t    tix_a [TL];

  always @(posedge clk) begin
    if (rst) begin
      sym_a <= 0;
      for (int i = 0; i < LA; i++) begin ram_a[i] <= '0; ram_sa[i] <= 0; end
      for (int i = 0; i < TL; i++) begin tv_a[i] <= 1'b0; tbm_a[i] <= '0; tix_a[i] <= '0; end
    end else if (clkena) begin
      if (oren_a && oraddr_a == AWA'(NA - 1)) sym_a <= sym_a + 1;
      ram_a[0]  <= oraddr_a;
      ram_sa[0] <= sym_a;
      for (int i = 1; i < LA; i++) begin ram_a[i] <= ram_a[i-1]; ram_sa[i] <= ram_sa[i-1]; end
      tv_a[0]  <= otree_val_a;
      tbm_a[0] <= bm_of(int'(ram_a[LA-1]));
      tix_a[0] <= idx_of(ram_sa[LA-1], int'(ram_a[LA-1]));
      for (int i = 1; i < TL; i++) begin tv_a[i] <= tv_a[i-1]; tbm_a[i] <= tbm_a[i-1]; tix_a[i] <= tix_a[i-1]; end
    end
  end

  assign itree_val_a = tv_a[TL-1] | spur_a;
  assign itree_bm_a  = tbm_a[TL-1];
  assign itree_idx_a = tix_a[TL-1];

  logic [AWB-1:0] ram_b [LB];
  int             ram_sb[LB];
  int             sym_b;
  logic           tv_b  [TL];
  trel_bm_t       tbm_b [TL];
  symb_m_idx_t    tix_b [TL];

  always @(posedge clk) begin
    if (rst) begin
      sym_b <= 0;
      for (int i = 0; i < LB; i++) begin ram_b[i] <= '0; ram_sb[i] <= 0; end
      for (int i = 0; i < TL; i++) begin tv_b[i] <= 1'b0; tbm_b[i] <= '0; tix_b[i] <= '0; end
    end else if (one_b) begin
      if (oren_b && oraddr_b == AWB'(NB - 1)) sym_b <= sym_b + 1;
      ram_b[0]  <= oraddr_b;
      ram_sb[0] <= sym_b;
      for (int i = 1; i < LB; i++) begin ram_b[i] <= ram_b[i-1]; ram_sb[i] <= ram_sb[i-1]; end
      tv_b[0]  <= otree_val_b;
      tbm_b[0] <= bm_of(int'(ram_b[LB-1]));
      tix_b[0] <= idx_of(ram_sb[LB-1], int'(ram_b[LB-1]));
      for (int i = 1; i < TL; i++) begin tv_b[i] <= tv_b[i-1]; tbm_b[i] <= tbm_b[i-1]; tix_b[i] <= tix_b[i-1]; end
    end
  end

  assign itree_val_b = tv_b[TL-1];
  assign itree_bm_b  = tbm_b[TL-1];
  assign itree_idx_b = tix_b[TL-1];

  // Reference model for instance A, stepped once per enabled cycle.
  typedef struct { int addr; int sym; } res_t;
  res_t res_q[$];
  int   iss_q[$];
  int   acc_q[$];
  bit   hist[$];
  int   ecnt, msym, run, run_max, n_sop, n_eop;
  bit   err_exp;

  always @(negedge clk) begin
    bit   exp_ordy, exp_idle, exp_oren, exp_tv;
    res_t r;
    int   a;
    if (rst) begin
      res_q.delete(); iss_q.delete(); acc_q.delete(); hist.delete();
      ecnt = 0; msym = 0; run = 0;
    end else if (clkena) begin
      exp_idle = (iss_q.size() == 0) && (res_q.size() == 0);
      exp_ordy = exp_idle || (iss_q.size() == 1);
      exp_oren = (iss_q.size() != 0);
      exp_tv   = (hist.size() >= LA) ? hist[hist.size() - LA] : 1'b0;
      chk("ordy", ordy_a, exp_ordy);
      chk("obusy", obusy_a, !exp_idle);
      chk("oren", oren_a, exp_oren);
      chk("otree_val", otree_val_a, exp_tv);
      chk("oerr", oerr_a, err_exp);
      hist.push_back(exp_oren);
      if (hist.size() > 8) void'(hist.pop_front());
      if (exp_oren) chk("oraddr", oraddr_a, iss_q.pop_front());
      if (oren_a) run++;
      else begin
        if (run > run_max) run_max = run;
        run = 0;
      end
      if (oval_a) begin
        if (osop_a) n_sop++;
        if (oeop_a) n_eop++;
        if (res_q.size() == 0) chk("oval_spurious", oval_a, 1'b0);
        else begin
          r = res_q.pop_front();
          chk("obm_addr", obm_addr_a, r.addr);
          chk("obm", obm_a, bm_of(r.addr));
          chk("osymb_m_idx", osymb_a, idx_of(r.sym, r.addr));
          chk("osop", osop_a, r.addr == 0);
          chk("oeop", oeop_a, r.addr == NA - 1);
          if (r.addr == 0) begin
            a = acc_q.pop_front();
            chk("latency", ecnt - a, 1 + LA + TL + 1);
          end
        end
      end
      if (ival_a && exp_ordy) begin
        for (int k = 0; k < NA; k++) begin
          iss_q.push_back(k);
          res_q.push_back('{addr: k, sym: msym});
        end
        acc_q.push_back(ecnt);
        msym++;
      end
      ecnt++;
    end
  end

  bit rnd_en;

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_en) clkena = ($urandom_range(0, 1) == 1);
  endtask

  task automatic send(input int n);
    int got = 0;
    int g   = 0;
    ival_a = 1'b1;
    while (got < n && g < 4000) begin
      @(negedge clk);
      if (ordy_a && clkena) got++;
      step();
      g++;
    end
    ival_a = 1'b0;
    chk("send_timeout", got, n);
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((iss_q.size() != 0 || res_q.size() != 0) && g < 4000) begin
      step();
      g++;
    end
    chk("idle_timeout", g < 4000, 1'b1);
    repeat (2) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running exp=finished");
    n_err++;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    int acc0, nacc, nres, niss, first_oval;
    bit found;
    rst = 1'b1; clkena = 1'b1; ival_a = 1'b0; spur_a = 1'b0; ival_b = 1'b0; one_b = 1'b1;
    err_exp = 1'b0; rnd_en = 1'b0; run_max = 0; n_sop = 0; n_eop = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_ordy", ordy_a, 1'b1);
    chk("rst_oren", oren_a, 1'b0);
    chk("rst_otree_val", otree_val_a, 1'b0);
    chk("rst_oval", oval_a, 1'b0);
    chk("rst_osop", osop_a, 1'b0);
    chk("rst_oeop", oeop_a, 1'b0);
    chk("rst_obusy", obusy_a, 1'b0);
    chk("rst_oerr", oerr_a, 1'b0);
    chk("rst_obm", obm_a, 0);
    chk("rst_obm_addr", obm_addr_a, 0);
    chk("rst_osymb", osymb_a, 0);

    // Single symbol.
    send(1);
    wait_idle();
    chk("single_sop", n_sop, 1);
    chk("single_eop", n_eop, 1);

    // Three symbols back to back.
    run_max = 0; n_sop = 0; n_eop = 0;
    send(3);
    wait_idle();
    chk("b2b_oren_run", run_max, 3 * NA);
    chk("b2b_sop", n_sop, 3);
    chk("b2b_eop", n_eop, 3);

    // Random clock enable during a symbol.
    rnd_en = 1'b1;
    send(1);
    wait_idle();
    rnd_en = 1'b0; clkena = 1'b1;

    // Random bursts, gaps and clock enable.
    for (int it = 0; it < 6; it++) begin
      rnd_en = ($urandom_range(0, 1) == 1);
      if (!rnd_en) clkena = 1'b1;
      send($urandom_range(1, 3));
      repeat ($urandom_range(0, 5)) step();
    end
    rnd_en = 1'b0; clkena = 1'b1;
    wait_idle();

    // Instance B: 8 branches, 3-cycle RAM, two symbols back to back.
    acc0 = -1; nacc = 0; nres = 0; niss = 0; first_oval = -1;
    ival_b = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (oren_b) begin
        chk("b_oraddr", oraddr_b, niss % NB);
        niss++;
      end
      if (oval_b) begin
        if (first_oval < 0) first_oval = c;
        chk("b_obm_addr", obm_addr_b, nres % NB);
        chk("b_obm", obm_b, bm_of(nres % NB));
        chk("b_oeop", oeop_b, (nres % NB) == NB - 1);
        nres++;
      end
      if (ival_b && ordy_b) begin
        if (acc0 < 0) acc0 = c;
        nacc++;
      end
      @(posedge clk);
      #1;
      if (nacc >= 2) ival_b = 1'b0;
    end
    chk("b_latency", first_oval - acc0, 1 + LB + TL + 1);
    chk("b_issued", niss, 2 * NB);
    chk("b_results", nres, 2 * NB);
    chk("b_oerr", oerr_b, 1'b0);

    // Reset on branch 7 mid-run, then a stray tree result.
    ival_a = 1'b1;
    found = 1'b0;
    for (int g = 0; g < 200 && !found; g++) begin
      step();
      if (oren_a && oraddr_a == AWA'(7)) found = 1'b1;
    end
    chk("rst_mid_found", found, 1'b1);
    rst = 1'b1; ival_a = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mid_rst_ordy", ordy_a, 1'b1);
    chk("mid_rst_oren", oren_a, 1'b0);
    chk("mid_rst_oval", oval_a, 1'b0);
    chk("mid_rst_obusy", obusy_a, 1'b0);
    spur_a = 1'b1;
    @(posedge clk);
    #1;
    spur_a = 1'b0;
    err_exp = 1'b1;
    chk("spur_oerr", oerr_a, 1'b1);
    chk("spur_oval", oval_a, 1'b0);
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
